serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised multi-bit subtractor computing a - b - bin over WIDTH bits.
- Processes DIGIT bits per clock, LSB first, using a ripple of full-subtractor cells, each built from two half-subtractor stages.
- Valid/ready on both input and output; one operation in flight at a time.
- Sits in the arithmetic library as the area-lean successor to the single-bit subtractor cells.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 1.
- DIGIT, 1, bits processed per clock; must divide WIDTH exactly (elaboration-time check, fatal if violated).
- STEPS, WIDTH/DIGIT, derived localparam (not overridable): number of RUN cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a, b, bin are valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- bin  in  1  borrow-in
- out_valid  out  1  diff and bout are valid
- out_ready  in  1  consumer accepts the result
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  out  1  borrow-out; 1 when a < b + bin (unsigned)

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low. Assertion forces state IDLE, diff=0, bout=0, out_valid=0, step counter=0, internal borrow=0.
  - in_ready=1 during and after reset, since the state is IDLE.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE), driven from state only, with no combinational path from in_valid or out_ready.
  - out_valid = (state==DONE), registered.
- IDLE:
  - On in_valid&in_ready at a rising edge: latch a and b into shift registers, latch bin into the borrow register, clear the counter, go to RUN.
  - Inputs are ignored at all other times.
- RUN:
  - Each edge consumes the low DIGIT bits of the a/b shift registers through a DIGIT-long full-subtractor ripple.
  - Per bit: d = x^y^c; c' = (~x&y) | (~(x^y)&c).
  - The DIGIT result bits shift into diff from the MSB end, so diff is fully LSB-aligned after STEPS edges.
  - The final borrow of the ripple is registered for the next digit.
  - When counter==STEPS-1 the edge also loads bout from the last borrow and moves to DONE.
- Latency: out_valid rises exactly STEPS clock edges after the accepting edge (STEPS=8 at default; 1 when DIGIT=WIDTH).
- DONE:
  - diff and bout are held stable while out_valid=1 and out_ready=0, for an unbounded number of cycles.
  - On out_ready=1 at an edge, go to IDLE; out_valid falls on that edge.
  - A new operation may be accepted no earlier than the following edge (minimum throughput: one result per STEPS+2 cycles).
- diff is not cleared on leaving DONE. It holds its last value until overwritten during the next RUN, and is meaningful only while out_valid=1.
- out_ready is ignored outside DONE; in_valid is ignored outside IDLE.
- Reset mid-RUN or mid-DONE aborts the operation: no out_valid pulse, and the result is lost.
- Arithmetic: pure unsigned modulo 2^WIDTH. Signed interpretation is left to the user; no overflow flag.

Decomposition:
- Shared package arith_pkg:
  - state enum sub_state_e {IDLE, RUN, DONE}
  - helper function clog2-based COUNT_W = max(1, $clog2(STEPS))
- Sub-module full_sub_cell(x, y, c_in, d, c_out): combinational, built from two half-subtractor stages plus an OR.
  - Instantiated DIGIT times in a generate loop to form the per-cycle ripple.

Test Plan:
- Basic operation (WIDTH=8, DIGIT=1): a=0x05, b=0x03, bin=0, out_ready=1 -> out_valid high 8 edges after acceptance, diff=0x02, bout=0, in_ready returns 1 one cycle after the output handshake.
- Wrap-around: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x80, b=0x80, bin=1 -> diff=0xFF, bout=1; a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> diff/bout stable, in_ready=0, and an in_valid pulse during this window is not accepted. Release -> one handshake, then IDLE.
- Reset abort: assert rst_n=0 asynchronously (between edges) 4 cycles into RUN -> out_valid, diff, bout are 0 immediately; after release, a fresh 0x10-0x01 yields 0x0F with no stale result.
- Wide digit (WIDTH=8, DIGIT=4): 0x3C-0x4B, bin=0 -> latency 2 edges, diff=0xF1, bout=1. Also check DIGIT=8 gives latency 1.
- Exhaustive (WIDTH=2, DIGIT=1): all 32 combinations of a, b, bin, with random out_ready stalls -> {bout, diff} matches a reference model of (a - b - bin) mod 8 in 3-bit two's complement.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state encoding and counter sizing.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    // Counter width for a given number of steps; never narrower than one bit.
    function automatic int count_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/full_sub_cell.sv
// One-bit full subtractor built from two half-subtractor stages and an OR.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic d,
    output logic c_out
);
    logic d1;
    logic b1;
    logic b2;

    // first half-subtractor: x - y
    assign d1 = x ^ y;
    assign b1 = ~x & y;

    // second half-subtractor: (x - y) - c_in
    assign d  = d1 ^ c_in;
    assign b2 = ~d1 & c_in;

    assign c_out = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: a - b - bin, DIGIT bits per clock, LSB first.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int STEPS   = WIDTH / DIGIT;
    localparam int COUNT_W = count_w(STEPS);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $fatal(1, "serial_subtractor: DIGIT must be >= 1 and divide WIDTH (WIDTH=%0d DIGIT=%0d)",
               WIDTH, DIGIT);
    end

    sub_state_e         state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;

    logic [DIGIT:0]     chain;
    logic [DIGIT-1:0]   dig;

    assign chain[0] = borrow_q;

    for (genvar g = 0; g < DIGIT; g++) begin : g_ripple
        full_sub_cell u_cell (
            .x     (a_q[g]),
            .y     (b_q[g]),
            .c_in  (chain[g]),
            .d     (dig[g]),
            .c_out (chain[g+1])
        );
    end

    // Next-state and datapath update; everything holds unless a state acts on it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        bout_d   = bout_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                // new digit enters at the MSB end so the result is LSB-aligned after STEPS shifts
                diff_d   = (diff_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
                borrow_d = chain[DIGIT];
                if (cnt_q == COUNT_W'(STEPS - 1)) begin
                    bout_d  = chain[DIGIT];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + COUNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor across several WIDTH/DIGIT configurations.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // index 0: W8/D1, 1: W8/D4, 2: W8/D8, 3: W2/D1
    logic [3:0] iv, rdy, bn;
    logic [7:0] av [4];
    logic [7:0] bv [4];
    logic [3:0] ov, irdy, bo;
    logic [7:0] dv [4];

    serial_subtractor_if #(.WIDTH(8)) bus0 ();
    serial_subtractor_if #(.WIDTH(8)) bus1 ();
    serial_subtractor_if #(.WIDTH(8)) bus2 ();
    serial_subtractor_if #(.WIDTH(2)) bus3 ();

    assign bus0.in_valid = iv[0];  assign bus0.out_ready = rdy[0];
    assign bus0.a = av[0];         assign bus0.b = bv[0];          assign bus0.bin = bn[0];
    assign ov[0] = bus0.out_valid; assign irdy[0] = bus0.in_ready;
    assign dv[0] = bus0.diff;      assign bo[0] = bus0.bout;

    assign bus1.in_valid = iv[1];  assign bus1.out_ready = rdy[1];
    assign bus1.a = av[1];         assign bus1.b = bv[1];          assign bus1.bin = bn[1];
    assign ov[1] = bus1.out_valid; assign irdy[1] = bus1.in_ready;
    assign dv[1] = bus1.diff;      assign bo[1] = bus1.bout;

    assign bus2.in_valid = iv[2];  assign bus2.out_ready = rdy[2];
    assign bus2.a = av[2];         assign bus2.b = bv[2];          assign bus2.bin = bn[2];
    assign ov[2] = bus2.out_valid; assign irdy[2] = bus2.in_ready;
    assign dv[2] = bus2.diff;      assign bo[2] = bus2.bout;

    assign bus3.in_valid = iv[3];  assign bus3.out_ready = rdy[3];
    assign bus3.a = av[3][1:0];    assign bus3.b = bv[3][1:0];     assign bus3.bin = bn[3];
    assign ov[3] = bus3.out_valid; assign irdy[3] = bus3.in_ready;
    assign dv[3] = {6'b0, bus3.diff}; assign bo[3] = bus3.bout;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    serial_subtractor #(.WIDTH(2), .DIGIT(1)) u_w2 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // present operands at a falling edge; the following rising edge accepts them
    task automatic start_op(input int idx, input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        av[idx] = a;
        bv[idx] = b;
        bn[idx] = c;
        iv[idx] = 1'b1;
        @(posedge clk);
        #1;
        iv[idx] = 1'b0;
    endtask

    // count edges from acceptance until out_valid; optionally toggle out_ready while running
    task automatic wait_done(input int idx, input int exp_lat, input bit rnd, input string tag);
        int lat  = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (ov[idx]) seen = 1'b1;
            else if (rnd) rdy[idx] = 1'($urandom_range(0, 1));
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic finish_op(input int idx, input string tag);
        rdy[idx] = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_ov_low"}, 32'(ov[idx]), 32'd0);
        chk({tag, "_in_ready"}, 32'(irdy[idx]), 32'd1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs [4] = '{
        '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0},
        '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1},
        '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1},
        '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0}
    };

    initial begin
        rst_n = 1'b0;
        iv = '0; rdy = '0; bn = '0;
        for (int i = 0; i < 4; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end

        #12;
        chk("rst_in_ready", 32'(irdy[0]), 32'd1);
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_diff", 32'(dv[0]), 32'd0);
        chk("rst_bout", 32'(bo[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic and wrap-around vectors, out_ready held high
        rdy[0] = 1'b1;
        for (int v = 0; v < 4; v++) begin
            start_op(0, vecs[v].a, vecs[v].b, vecs[v].c);
            wait_done(0, 8, 1'b0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_diff", v), 32'(dv[0]), 32'(vecs[v].d));
            chk($sformatf("vec%0d_bout", v), 32'(bo[0]), 32'(vecs[v].bo));
            finish_op(0, $sformatf("vec%0d", v));
        end

        // backpressure: 0x37 - 0x12 = 0x25, stalled for 5 cycles with a rejected in_valid pulse
        rdy[0] = 1'b0;
        start_op(0, 8'h37, 8'h12, 1'b0);
        wait_done(0, 8, 1'b0, "bp");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            iv[0] = 1'b1;
            av[0] = 8'hAA;
            bv[0] = 8'h01;
            @(posedge clk);
            #1;
            iv[0] = 1'b0;
            chk("bp_ov_hold", 32'(ov[0]), 32'd1);
            chk("bp_in_ready_low", 32'(irdy[0]), 32'd0);
            chk("bp_diff_hold", 32'(dv[0]), 32'h25);
            chk("bp_bout_hold", 32'(bo[0]), 32'd0);
        end
        finish_op(0, "bp");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_stay_idle", 32'(irdy[0]), 32'd1);
            chk("bp_no_result", 32'(ov[0]), 32'd0);
        end

        // reset abort 4 edges into RUN
        rdy[0] = 1'b1;
        start_op(0, 8'h55, 8'h22, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_ov", 32'(ov[0]), 32'd0);
        chk("abort_diff", 32'(dv[0]), 32'd0);
        chk("abort_bout", 32'(bo[0]), 32'd0);
        chk("abort_in_ready", 32'(irdy[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("abort_no_stale", 32'(ov[0]), 32'd0);
        end
        start_op(0, 8'h10, 8'h01, 1'b0);
        wait_done(0, 8, 1'b0, "post_abort");
        chk("post_abort_diff", 32'(dv[0]), 32'h0F);
        chk("post_abort_bout", 32'(bo[0]), 32'd0);
        finish_op(0, "post_abort");

        // wide digits: 0x3C - 0x4B = 0xF1 with borrow
        rdy[1] = 1'b1;
        start_op(1, 8'h3C, 8'h4B, 1'b0);
        wait_done(1, 2, 1'b0, "d4");
        chk("d4_diff", 32'(dv[1]), 32'hF1);
        chk("d4_bout", 32'(bo[1]), 32'd1);
        finish_op(1, "d4");

        rdy[2] = 1'b1;
        start_op(2, 8'h3C, 8'h4B, 1'b0);
        wait_done(2, 1, 1'b0, "d8");
        chk("d8_diff", 32'(dv[2]), 32'hF1);
        chk("d8_bout", 32'(bo[2]), 32'd1);
        finish_op(2, "d8");

        // exhaustive WIDTH=2 with random out_ready stalls
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    logic [2:0] exp3;
                    int stall;
                    exp3 = 3'(a - b - c);
                    rdy[3] = 1'($urandom_range(0, 1));
                    start_op(3, 8'(a), 8'(b), 1'(c));
                    wait_done(3, 2, 1'b1, "ex");
                    rdy[3] = 1'b0;
                    chk($sformatf("ex_%0d_%0d_%0d", a, b, c), 32'({bo[3], dv[3][1:0]}), 32'(exp3));
                    stall = $urandom_range(0, 3);
                    for (int s = 0; s < stall; s++) begin
                        @(posedge clk);
                        #1;
                        chk("ex_stall_hold", 32'({ov[3], bo[3], dv[3][1:0]}), 32'({1'b1, exp3}));
                    end
                    finish_op(3, "ex");
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
